pes_coin_front: RTL and testbench



---
 rtl/pes_vm_pkg.sv | 21 ++
 rtl/pes_sync2.sv | 26 ++
 rtl/pes_coin_front.sv | 125 ++++++++++++
 tb/tb_pes_coin_front.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pes_vm_pkg.sv
// Shared vending-machine definitions: coin codes used by the coin front end and
// the downstream FSM, plus the front-end state encoding.
package pes_vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_QUAL     = 2'd1,
    ST_WAIT_REL = 2'd2,
    ST_FAULT    = 2'd3
  } fe_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pes_sync2.sv
// Two-flop synchroniser for asynchronous level inputs, cleared by synchronous reset.
module pes_sync2 #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pes_coin_front.sv
// Coin acceptor front end: synchronise, debounce and qualify the two slot sensors,
// emit one coin code or reject pulse per coin, and latch a sticky stuck-sensor fault.
module pes_coin_front
  import pes_vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_PULSE       = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  input  logic       inhibit,
  output logic [1:0] coin_code,
  output logic       reject,
  output logic       fault,
  output logic [7:0] coins_accepted
);

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_PULSE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0] s;

  pes_sync2 #(.W(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     ({coin10_raw, coin5_raw}),
    .q     (s)
  );

  fe_state_e        state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             reject_q, reject_d;
  logic             fault_q, fault_d;
  logic [7:0]       coins_q, coins_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    code_d   = COIN_NONE;
    reject_d = 1'b0;
    fault_d  = fault_q;
    coins_d  = coins_q;
    case (state_q)
      ST_IDLE: begin
        if (s != COIN_NONE) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (s == COIN_NONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (s != cand_q) begin
          cand_d = s;
          cnt_d  = CNT_ONE;
        end else if (cnt_q == QUAL_LAST) begin
          // Qualify edge: the only point where inhibit is consulted.
          cnt_d   = '0;
          state_d = ST_WAIT_REL;
          if (cand_q == COIN_BOTH || inhibit) begin
            reject_d = 1'b1;
          end else begin
            code_d  = cand_q;
            coins_d = sat_inc8(coins_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT_REL: begin
        if (s == COIN_NONE) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == HOLD_LAST) begin
          cnt_d   = cnt_q + CNT_ONE;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cand_q   <= COIN_NONE;
      cnt_q    <= '0;
      code_q   <= COIN_NONE;
      reject_q <= 1'b0;
      fault_q  <= 1'b0;
      coins_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      reject_q <= reject_d;
      fault_q  <= fault_d;
      coins_q  <= coins_d;
    end
  end

  assign coin_code      = code_q;
  assign reject         = reject_q;
  assign fault          = fault_q;
  assign coins_accepted = coins_q;

endmodule

// File: tb/tb_pes_coin_front.sv
// Directed bench for pes_coin_front: coin timing, debounce, reject, fault and saturation.
module tb_pes_coin_front;

  logic       clock;
  logic       reset;
  logic       coin5_raw;
  logic       coin10_raw;
  logic       inhibit;
  logic [1:0] coin_code;
  logic       reject;
  logic       fault;
  logic [7:0] coins_accepted;

  int n_pass;
  int n_total;
  int cyc;

  // Monitor totals, only ever written by the monitor process.
  int n5, n10, n11, nrej, nwide;
  int last5, last10, lastrej, fault_cyc;
  logic prev_act;
  logic prev_fault;

  pes_coin_front dut (
    .clock          (clock),
    .reset          (reset),
    .coin5_raw      (coin5_raw),
    .coin10_raw     (coin10_raw),
    .inhibit        (inhibit),
    .coin_code      (coin_code),
    .reject         (reject),
    .fault          (fault),
    .coins_accepted (coins_accepted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    n5 = 0; n10 = 0; n11 = 0; nrej = 0; nwide = 0;
    last5 = -1; last10 = -1; lastrej = -1; fault_cyc = -1;
    prev_act = 1'b0; prev_fault = 1'b0;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (coin_code == 2'b01) begin n5++; last5 = cyc; end
      if (coin_code == 2'b10) begin n10++; last10 = cyc; end
      if (coin_code == 2'b11) n11++;
      if (reject) begin nrej++; lastrej = cyc; end
      if ((coin_code != 2'b00 || reject) && prev_act) nwide++;
      if (fault && !prev_fault) fault_cyc = cyc;
    end
    prev_act   = !reset && (coin_code != 2'b00 || reject);
    prev_fault = fault;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Hold {coin10_raw, coin5_raw} = v for n sampling edges, then release.
  task automatic drive(input logic [1:0] v, input int n);
    {coin10_raw, coin5_raw} = v;
    step(n);
    {coin10_raw, coin5_raw} = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(3);
    n_total++; if (coin_code !== 2'b00) $display("FAIL reset_code got %b want 00", coin_code); else n_pass++;
    n_total++; if (reject !== 1'b0) $display("FAIL reset_reject got %b want 0", reject); else n_pass++;
    n_total++; if (fault !== 1'b0) $display("FAIL reset_fault got %b want 0", fault); else n_pass++;
    n_total++; if (coins_accepted !== 8'd0) $display("FAIL reset_coins got %0d want 0", coins_accepted); else n_pass++;
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_coin5();
    int e0, b5, brej;
    b5 = n5; brej = nrej; e0 = cyc;
    drive(2'b01, 10);
    step(6);
    n_total++; if (n5 - b5 !== 1) $display("FAIL coin5_count got %0d want 1", n5 - b5); else n_pass++;
    n_total++; if (last5 !== e0 + 6) $display("FAIL coin5_latency got %0d want %0d", last5, e0 + 6); else n_pass++;
    n_total++; if (nrej - brej !== 0) $display("FAIL coin5_reject got %0d want 0", nrej - brej); else n_pass++;
    n_total++; if (coins_accepted !== 8'd1) $display("FAIL coin5_coins got %0d want 1", coins_accepted); else n_pass++;
  endtask

  task automatic test_coin10_short_then_valid();
    int b10, brej, e0;
    b10 = n10; brej = nrej;
    drive(2'b10, 3);
    step(8);
    n_total++; if (n10 - b10 !== 0) $display("FAIL short10_code got %0d want 0", n10 - b10); else n_pass++;
    n_total++; if (nrej - brej !== 0) $display("FAIL short10_reject got %0d want 0", nrej - brej); else n_pass++;
    n_total++; if (coins_accepted !== 8'd1) $display("FAIL short10_coins got %0d want 1", coins_accepted); else n_pass++;
    e0 = cyc;
    drive(2'b10, 6);
    step(6);
    n_total++; if (n10 - b10 !== 1) $display("FAIL coin10_count got %0d want 1", n10 - b10); else n_pass++;
    n_total++; if (last10 !== e0 + 6) $display("FAIL coin10_latency got %0d want %0d", last10, e0 + 6); else n_pass++;
    n_total++; if (coins_accepted !== 8'd2) $display("FAIL coin10_coins got %0d want 2", coins_accepted); else n_pass++;
  endtask

  task automatic test_both_sensors();
    int b5, b10, brej, e0;
    b5 = n5; b10 = n10; brej = nrej; e0 = cyc;
    drive(2'b11, 8);
    step(6);
    n_total++; if (nrej - brej !== 1) $display("FAIL both_reject got %0d want 1", nrej - brej); else n_pass++;
    n_total++; if (lastrej !== e0 + 6) $display("FAIL both_latency got %0d want %0d", lastrej, e0 + 6); else n_pass++;
    n_total++; if ((n5 - b5) + (n10 - b10) !== 0) $display("FAIL both_code got %0d want 0", (n5 - b5) + (n10 - b10)); else n_pass++;
    n_total++; if (coins_accepted !== 8'd2) $display("FAIL both_coins got %0d want 2", coins_accepted); else n_pass++;
  endtask

  task automatic test_inhibit();
    int b10, brej;
    b10 = n10; brej = nrej;
    inhibit = 1'b1;
    drive(2'b10, 8);
    step(6);
    inhibit = 1'b0;
    n_total++; if (nrej - brej !== 1) $display("FAIL inhibit_reject got %0d want 1", nrej - brej); else n_pass++;
    n_total++; if (n10 - b10 !== 0) $display("FAIL inhibit_code got %0d want 0", n10 - b10); else n_pass++;
    drive(2'b10, 8);
    step(6);
    n_total++; if (n10 - b10 !== 1) $display("FAIL uninhibit_code got %0d want 1", n10 - b10); else n_pass++;
    // Inhibit during early qualification only, low at the qualify edge.
    coin10_raw = 1'b1;
    inhibit = 1'b1;
    step(3);
    inhibit = 1'b0;
    step(5);
    coin10_raw = 1'b0;
    step(6);
    n_total++; if (n10 - b10 !== 2) $display("FAIL inhibit_early_code got %0d want 2", n10 - b10); else n_pass++;
    n_total++; if (nrej - brej !== 1) $display("FAIL inhibit_early_reject got %0d want 1", nrej - brej); else n_pass++;
    n_total++; if (coins_accepted !== 8'd4) $display("FAIL inhibit_coins got %0d want 4", coins_accepted); else n_pass++;
  endtask

  task automatic test_bounce();
    int b5;
    b5 = n5;
    drive(2'b01, 2);
    step(1);
    drive(2'b01, 6);
    step(6);
    n_total++; if (n5 - b5 !== 1) $display("FAIL bounce_count got %0d want 1", n5 - b5); else n_pass++;
    n_total++; if (coins_accepted !== 8'd5) $display("FAIL bounce_coins got %0d want 5", coins_accepted); else n_pass++;
  endtask

  task automatic test_reset_mid_qual();
    int b5, brej, e1;
    b5 = n5; brej = nrej;
    coin5_raw = 1'b1;
    step(3);
    reset = 1'b1;
    coin5_raw = 1'b0;
    step(2);
    reset = 1'b0;
    step(8);
    n_total++; if (n5 - b5 !== 0) $display("FAIL rstqual_code got %0d want 0", n5 - b5); else n_pass++;
    n_total++; if (nrej - brej !== 0) $display("FAIL rstqual_reject got %0d want 0", nrej - brej); else n_pass++;
    n_total++; if (coins_accepted !== 8'd0) $display("FAIL rstqual_coins got %0d want 0", coins_accepted); else n_pass++;
    // Sensor held across reset is a fresh coin once reset drops.
    coin5_raw = 1'b1;
    step(3);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    e1 = cyc;
    step(10);
    coin5_raw = 1'b0;
    step(5);
    n_total++; if (n5 - b5 !== 1) $display("FAIL rstheld_count got %0d want 1", n5 - b5); else n_pass++;
    n_total++; if (last5 !== e1 + 6) $display("FAIL rstheld_latency got %0d want %0d", last5, e1 + 6); else n_pass++;
  endtask

  task automatic test_fault();
    int b5, b10, brej, e0;
    do_reset();
    step(2);
    b5 = n5; b10 = n10; brej = nrej; e0 = cyc;
    drive(2'b01, 40);
    step(5);
    n_total++; if (n5 - b5 !== 1) $display("FAIL fault_coin got %0d want 1", n5 - b5); else n_pass++;
    n_total++; if (fault_cyc !== e0 + 22) $display("FAIL fault_time got %0d want %0d", fault_cyc, e0 + 22); else n_pass++;
    n_total++; if (fault !== 1'b1) $display("FAIL fault_set got %b want 1", fault); else n_pass++;
    drive(2'b10, 8);
    step(6);
    n_total++; if ((n10 - b10) + (nrej - brej) !== 0) $display("FAIL fault_ignore got %0d want 0", (n10 - b10) + (nrej - brej)); else n_pass++;
    n_total++; if (fault !== 1'b1) $display("FAIL fault_sticky got %b want 1", fault); else n_pass++;
    n_total++; if (coins_accepted !== 8'd1) $display("FAIL fault_coins got %0d want 1", coins_accepted); else n_pass++;
    reset = 1'b1;
    step(2);
    n_total++; if (fault !== 1'b0) $display("FAIL fault_clear got %b want 0", fault); else n_pass++;
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_saturate();
    int b5;
    do_reset();
    step(2);
    b5 = n5;
    for (int i = 0; i < 255; i++) begin
      drive(2'b01, 5);
      step(2);
    end
    n_total++; if (coins_accepted !== 8'd255) $display("FAIL sat_255 got %0d want 255", coins_accepted); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 5);
      step(2);
    end
    step(4);
    n_total++; if (coins_accepted !== 8'd255) $display("FAIL sat_hold got %0d want 255", coins_accepted); else n_pass++;
    n_total++; if (n5 - b5 !== 260) $display("FAIL sat_pulses got %0d want 260", n5 - b5); else n_pass++;
  endtask

  task automatic test_protocol();
    n_total++; if (n11 !== 0) $display("FAIL code11_seen got %0d want 0", n11); else n_pass++;
    n_total++; if (nwide !== 0) $display("FAIL pulse_width got %0d wide want 0", nwide); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    coin5_raw = 1'b0;
    coin10_raw = 1'b0;
    inhibit = 1'b0;
    test_reset();
    test_coin5();
    test_coin10_short_then_valid();
    test_both_sensors();
    test_inhibit();
    test_bounce();
    test_reset_mid_qual();
    test_fault();
    test_saturate();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
